// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default bit timing,
// kept here so a transmitter can reuse them.
package uart_pkg;

  // 25 MHz system clock at 115200 baud.
  localparam int UART_CLKS_PER_BIT = 217;

  typedef logic [2:0] uart_rx_state_t;

  localparam uart_rx_state_t ST_IDLE  = 3'd0;
  localparam uart_rx_state_t ST_START = 3'd1;
  localparam uart_rx_state_t ST_DATA  = 3'd2;
  localparam uart_rx_state_t ST_STOP  = 3'd3;
  localparam uart_rx_state_t ST_BREAK = 3'd4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing asynchronous inputs into the i_clk domain.
module sync_2ff #(
  parameter int   WIDTH   = 1,
  parameter logic DEFAULT = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Metastability chain, preset to the idle level of the line.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      meta_r <= {WIDTH{DEFAULT}};
      sync_r <= {WIDTH{DEFAULT}};
    end else begin
      meta_r <= i_d;
      sync_r <= meta_r;
    end
  end

  assign o_q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, a one-byte holding register with
// valid/ready handshake, and frame-error / overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int   CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter logic SYNC_DEFAULT = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

  logic           rx_s;
  uart_rx_state_t state_r;
  uart_rx_state_t state_nxt_s;
  logic [CW-1:0]  cnt_r;
  logic [CW-1:0]  cnt_nxt_s;
  logic [2:0]     idx_r;
  logic [2:0]     idx_nxt_s;
  logic [7:0]     shreg_r;
  logic [7:0]     shreg_nxt_s;
  logic           cnt_zero_s;
  logic           byte_done_s;
  logic           frame_err_s;
  logic           handshake_s;

  sync_2ff #(
    .WIDTH   (1),
    .DEFAULT (SYNC_DEFAULT)
  ) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_rx),
    .o_q     (rx_s)
  );

  assign cnt_zero_s  = (cnt_r == CNT_ZERO);
  assign handshake_s = o_valid & i_ready;

  // Frame sequencing; the counter only decrements while non-zero.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    shreg_nxt_s = shreg_r;
    byte_done_s = 1'b0;
    frame_err_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!rx_s) begin
          state_nxt_s = ST_START;
          cnt_nxt_s   = HALF_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (!cnt_zero_s) begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end else if (!rx_s) begin
          state_nxt_s = ST_DATA;
          cnt_nxt_s   = FULL_LOAD;
          idx_nxt_s   = 3'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (!cnt_zero_s) begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end else begin
          shreg_nxt_s = {rx_s, shreg_r[7:1]};
          cnt_nxt_s   = FULL_LOAD;
          idx_nxt_s   = idx_r + 3'd1;
          if (idx_r == 3'd7) begin
            state_nxt_s = ST_STOP;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end
      end
      ST_STOP: begin
        if (!cnt_zero_s) begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end else if (rx_s) begin
          byte_done_s = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          frame_err_s = 1'b1;
          state_nxt_s = ST_BREAK;
        end
      end
      ST_BREAK: begin
        // Wait out a held-low line so it reports a single frame error.
        if (rx_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BREAK;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // State registers, holding register and status pulses.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      idx_r       <= 3'd0;
      shreg_r     <= 8'h00;
      o_data      <= 8'h00;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      idx_r       <= idx_nxt_s;
      shreg_r     <= shreg_nxt_s;
      o_frame_err <= frame_err_s;
      o_busy      <= (state_nxt_s != ST_IDLE);
      o_overrun   <= 1'b0;
      if (byte_done_s && (!o_valid || i_ready)) begin
        o_data  <= shreg_r;
        o_valid <= 1'b1;
      end else if (byte_done_s) begin
        // Holding register still owned by the consumer: keep it, drop the new byte.
        o_overrun <= 1'b1;
      end else if (handshake_s) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       ferr;
  logic       ovr;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int valid_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         obs_cyc_q[$];

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .SYNC_DEFAULT (1'b1)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx        (rx),
    .o_data      (data),
    .o_valid     (valid),
    .i_ready     (ready),
    .o_frame_err (ferr),
    .o_overrun   (ovr),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record handshakes and pulses on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (valid && ready) begin
      obs_q.push_back(data);
      obs_cyc_q.push_back(cyc);
    end
    if (ferr) ferr_cnt <= ferr_cnt + 1;
    if (ovr) ovr_cnt <= ovr_cnt + 1;
    if (valid) valid_cnt <= valid_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      tick(CPB);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    ready = 1'b0;
    tick(4);
    vectors++; if (data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", data); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", valid); end
    vectors++; if (ferr !== 1'b0) begin miscompares++; $display("FAIL reset_ferr: got %b want 0", ferr); end
    vectors++; if (ovr !== 1'b0) begin miscompares++; $display("FAIL reset_ovr: got %b want 0", ovr); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    tick(8);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic();
    int start, v0, f0, o0;
    ready = 1'b1;
    v0 = valid_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    start = cyc;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    tick(4);
    vectors++; if (obs_q.size() != 1) begin miscompares++; $display("FAIL basic_count: got %0d want 1", obs_q.size()); end
    while (exp_q.size() > 0) begin
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++; $display("FAIL basic_missing: got none want %h", exp_q[0]); void'(exp_q.pop_front());
      end else begin
        if (obs_q[0] !== exp_q[0]) begin miscompares++; $display("FAIL basic_data: got %h want %h", obs_q[0], exp_q[0]); end
        vectors++;
        if (obs_cyc_q[0] - start != 155) begin miscompares++; $display("FAIL basic_latency: got %0d want 155", obs_cyc_q[0] - start); end
        void'(exp_q.pop_front()); void'(obs_q.pop_front()); void'(obs_cyc_q.pop_front());
      end
    end
    vectors++; if (valid_cnt - v0 != 1) begin miscompares++; $display("FAIL basic_valid_cycles: got %0d want 1", valid_cnt - v0); end
    vectors++; if (ferr_cnt - f0 != 0 || ovr_cnt - o0 != 0) begin miscompares++; $display("FAIL basic_pulses: got ferr %0d ovr %0d want 0 0", ferr_cnt - f0, ovr_cnt - o0); end
  endtask

  task automatic test_glitch();
    int v0, f0, o0;
    v0 = valid_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    rx = 1'b0;
    tick(4);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL glitch_busy_start: got %b want 1", busy); end
    tick(1);
    rx = 1'b1;
    tick(30);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL glitch_busy_idle: got %b want 0", busy); end
    vectors++; if (obs_q.size() != 0 || valid_cnt != v0) begin miscompares++; $display("FAIL glitch_valid: got %0d cycles want 0", valid_cnt - v0); end
    vectors++; if (ferr_cnt != f0 || ovr_cnt != o0) begin miscompares++; $display("FAIL glitch_pulses: got ferr %0d ovr %0d want 0 0", ferr_cnt - f0, ovr_cnt - o0); end
  endtask

  task automatic test_frame_err();
    int v0, f0;
    ready = 1'b1;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    tick(100);
    rx = 1'b1;
    tick(8);
    vectors++; if (ferr_cnt - f0 != 1) begin miscompares++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt - f0); end
    vectors++; if (valid_cnt != v0 || obs_q.size() != 0) begin miscompares++; $display("FAIL ferr_valid: got %0d cycles want 0", valid_cnt - v0); end
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    tick(4);
    vectors++; if (obs_q.size() != 1) begin miscompares++; $display("FAIL ferr_next_count: got %0d want 1", obs_q.size()); end
    while (exp_q.size() > 0) begin
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++; $display("FAIL ferr_next_missing: got none want %h", exp_q[0]); void'(exp_q.pop_front());
      end else begin
        if (obs_q[0] !== exp_q[0]) begin miscompares++; $display("FAIL ferr_next_data: got %h want %h", obs_q[0], exp_q[0]); end
        void'(exp_q.pop_front()); void'(obs_q.pop_front()); void'(obs_cyc_q.pop_front());
      end
    end
    vectors++; if (ferr_cnt - f0 != 1) begin miscompares++; $display("FAIL ferr_after_next: got %0d want 1", ferr_cnt - f0); end
  endtask

  task automatic test_overrun();
    int o0;
    ready = 1'b0;
    o0 = ovr_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(4);
    vectors++; if (data !== 8'h11) begin miscompares++; $display("FAIL ovr_data_hold: got %h want 11", data); end
    vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL ovr_valid_hold: got %b want 1", valid); end
    vectors++; if (ovr_cnt - o0 != 1) begin miscompares++; $display("FAIL ovr_count: got %0d want 1", ovr_cnt - o0); end
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL ovr_valid_clear: got %b want 0", valid); end
    tick(2);
    vectors++; if (obs_q.size() != 1) begin miscompares++; $display("FAIL ovr_handshakes: got %0d want 1", obs_q.size()); end
    while (exp_q.size() > 0) begin
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++; $display("FAIL ovr_missing: got none want %h", exp_q[0]); void'(exp_q.pop_front());
      end else begin
        if (obs_q[0] !== exp_q[0]) begin miscompares++; $display("FAIL ovr_drain_data: got %h want %h", obs_q[0], exp_q[0]); end
        void'(exp_q.pop_front()); void'(obs_q.pop_front()); void'(obs_cyc_q.pop_front());
      end
    end
  endtask

  task automatic test_back_to_back();
    int o0;
    ready = 1'b0;
    exp_q.push_back(8'h44);
    send_frame(8'h44, 1'b1);
    tick(4);
    o0 = ovr_cnt;
    exp_q.push_back(8'h55);
    fork
      send_frame(8'h55, 1'b1);
      begin
        tick(154);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
      end
    join
    vectors++; if (data !== 8'h55) begin miscompares++; $display("FAIL b2b_data: got %h want 55", data); end
    vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid: got %b want 1", valid); end
    vectors++; if (ovr_cnt != o0) begin miscompares++; $display("FAIL b2b_overrun: got %0d want 0", ovr_cnt - o0); end
    ready = 1'b1;
    tick(3);
    vectors++; if (obs_q.size() != 2) begin miscompares++; $display("FAIL b2b_count: got %0d want 2", obs_q.size()); end
    while (exp_q.size() > 0) begin
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++; $display("FAIL b2b_missing: got none want %h", exp_q[0]); void'(exp_q.pop_front());
      end else begin
        if (obs_q[0] !== exp_q[0]) begin miscompares++; $display("FAIL b2b_order: got %h want %h", obs_q[0], exp_q[0]); end
        void'(exp_q.pop_front()); void'(obs_q.pop_front()); void'(obs_cyc_q.pop_front());
      end
    end
  endtask

  task automatic test_reset_midframe();
    int f0, o0;
    ready = 1'b1;
    f0 = ferr_cnt; o0 = ovr_cnt;
    fork
      send_frame(8'hF0, 1'b1);
      begin
        tick(84);
        rst_n = 1'b0;
        tick(3);
        vectors++; if (busy !== 1'b0 || valid !== 1'b0) begin miscompares++; $display("FAIL midrst_outputs: got busy %b valid %b want 0 0", busy, valid); end
        rst_n = 1'b1;
      end
    join
    tick(4);
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL midrst_no_output: got %0d bytes want 0", obs_q.size()); end
    vectors++; if (ferr_cnt != f0 || ovr_cnt != o0) begin miscompares++; $display("FAIL midrst_pulses: got ferr %0d ovr %0d want 0 0", ferr_cnt - f0, ovr_cnt - o0); end
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    tick(4);
    vectors++; if (obs_q.size() != 1) begin miscompares++; $display("FAIL midrst_next_count: got %0d want 1", obs_q.size()); end
    while (exp_q.size() > 0) begin
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++; $display("FAIL midrst_missing: got none want %h", exp_q[0]); void'(exp_q.pop_front());
      end else begin
        if (obs_q[0] !== exp_q[0]) begin miscompares++; $display("FAIL midrst_next_data: got %h want %h", obs_q[0], exp_q[0]); end
        void'(exp_q.pop_front()); void'(obs_q.pop_front()); void'(obs_cyc_q.pop_front());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    ready = 1'b0;
    tick(1);
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
